// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } ctrl_state_t;

   localparam int REG_AW = 5;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side bundle: hazard inputs, data-memory handshake and register controls.
// Handshake: dmem_valid is the controller's request; an access completes in the cycle dmem_valid & dmem_ready.
interface pipe_stall_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic              ex_mem_r_en;
   logic [REG_AW-1:0] ex_dest;
   logic              ex_br_taken;
   logic              mem_access;
   logic              dmem_ready;
   logic              dmem_valid;
   logic              pc_en;
   logic              ifid_en;
   logic              ifid_flush;
   logic              idex_en;
   logic              idex_flush;
   logic              exmem_en;
   logic              memwb_en;
   logic              memwb_bubble;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_r_en, ex_dest,
             ex_br_taken, mem_access, dmem_ready,
      input  dmem_valid, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_en, memwb_bubble
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_r_en, ex_dest,
             ex_br_taken, mem_access, dmem_ready,
      output dmem_valid, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_en, memwb_bubble
   );
endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the source operands of ID; x0 never matches.
module hazard_detect #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              ex_mem_r_en,
   input  logic [REG_AW-1:0] ex_dest,
   output logic              load_use
);
   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_rs1_used && (id_rs1 == ex_dest);
   assign rs2_hit  = id_rs2_used && (id_rs2 == ex_dest);
   assign load_use = ex_mem_r_en && (ex_dest != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: memory-wait freeze, branch squash, load-use bubble.
module pipe_stall_ctrl #(
   parameter int REG_AW   = 5,
   parameter int TIMEOUT  = 64,
   parameter int STALL_CW = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   pipe_stall_ctrl_if.slave          p,
   output logic                      mem_err,
   output logic [STALL_CW-1:0]       stall_cycles,
   output pipe_ctrl_pkg::ctrl_state_t dbg_state
);
   import pipe_ctrl_pkg::*;

   // wait_cnt only has to reach TIMEOUT-1.
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   ctrl_state_t    state_q, state_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic           err_set;
   logic           load_use;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .id_rs1      (p.id_rs1),
      .id_rs2      (p.id_rs2),
      .id_rs1_used (p.id_rs1_used),
      .id_rs2_used (p.id_rs2_used),
      .ex_mem_r_en (p.ex_mem_r_en),
      .ex_dest     (p.ex_dest),
      .load_use    (load_use)
   );

   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= RUN;
         wait_q       <= '0;
         mem_err      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (err_set) mem_err <= 1'b1;
         if (!p.pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_set = 1'b0;
      case (state_q)
         RUN: begin
            if (p.mem_access && !p.dmem_ready) begin
               state_d = MEM_WAIT;
               wait_d  = WCW'(1);
            end
         end
         MEM_WAIT: begin
            if (p.dmem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if ((TIMEOUT != 0) && (int'(wait_q) == TIMEOUT - 1)) begin
               state_d = ERR;
               err_set = 1'b1;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         ERR:     state_d = ERR;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      p.dmem_valid   = 1'b0;
      p.pc_en        = 1'b1;
      p.ifid_en      = 1'b1;
      p.ifid_flush   = 1'b0;
      p.idex_en      = 1'b1;
      p.idex_flush   = 1'b0;
      p.exmem_en     = 1'b1;
      p.memwb_en     = 1'b1;
      p.memwb_bubble = 1'b0;
      if (!rstn || (state_q == ERR) || (state_q != RUN && state_q != MEM_WAIT)) begin
         p.pc_en        = 1'b0;
         p.ifid_en      = 1'b0;
         p.idex_en      = 1'b0;
         p.exmem_en     = 1'b0;
         p.memwb_en     = 1'b0;
         p.ifid_flush   = 1'b1;
         p.idex_flush   = 1'b1;
         p.memwb_bubble = 1'b1;
      end else begin
         p.dmem_valid = (state_q == MEM_WAIT) || p.mem_access;
         if (p.dmem_valid && !p.dmem_ready) begin
            // Freeze the front; WB keeps draining with bubbles.
            p.pc_en        = 1'b0;
            p.ifid_en      = 1'b0;
            p.idex_en      = 1'b0;
            p.exmem_en     = 1'b0;
            p.memwb_bubble = 1'b1;
         end else if (state_q == RUN) begin
            if (p.ex_br_taken) begin
               p.ifid_flush = 1'b1;
               p.idex_flush = 1'b1;
            end else if (load_use) begin
               p.pc_en      = 1'b0;
               p.ifid_en    = 1'b0;
               p.idex_flush = 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized scoreboard bench for pipe_stall_ctrl against a cycle-level reference model.
module tb_pipe_stall_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int RAW      = 5;
   localparam int TOUT     = 4;
   localparam int SCW      = 5;
   localparam int SMAX     = (1 << SCW) - 1;
   localparam int W        = 10 + SCW;

   logic           clk;
   logic           rstn;
   logic           mem_err;
   logic [SCW-1:0] stall_cycles;
   ctrl_state_t    dbg_state;

   pipe_stall_ctrl_if #(.REG_AW(RAW)) bus ();

   pipe_stall_ctrl #(.REG_AW(RAW), .TIMEOUT(TOUT), .STALL_CW(SCW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .p            (bus.slave),
      .mem_err      (mem_err),
      .stall_cycles (stall_cycles),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   logic [W-1:0] exp_q[$];
   string        phase_q[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;

   // reference model state
   int m_unserved = 0;
   bit m_err      = 1'b0;
   int m_stall    = 0;

   always @(negedge clk) begin
      logic [W-1:0] act, exp_v;
      string        ph;
      cyc++;
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         ph    = phase_q.pop_front();
         act   = {bus.dmem_valid, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                  bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.memwb_bubble,
                  mem_err, stall_cycles};
         n_tests++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b (dv,pc,ifid,iff,idex,idf,exm,mwb,bub,err,stall)",
                     ph, cyc, act, exp_v);
         end
      end
   end

   // driver: apply one cycle of inputs, push the expected response, advance the model
   task automatic step(input string ph, input bit rn, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit ld, input int dest,
                       input bit br, input bit ma, input bit rdy);
      bit dv, pc, ie, ifl, xe, xfl, me, we, wb, req, haz;
      @(posedge clk);
      #1;
      rstn            = rn;
      bus.id_rs1      = RAW'(rs1);
      bus.id_rs2      = RAW'(rs2);
      bus.id_rs1_used = u1;
      bus.id_rs2_used = u2;
      bus.ex_mem_r_en = ld;
      bus.ex_dest     = RAW'(dest);
      bus.ex_br_taken = br;
      bus.mem_access  = ma;
      bus.dmem_ready  = rdy;

      req = (m_unserved > 0) || ma;
      haz = ld && (dest != 0) && ((u1 && rs1 == dest) || (u2 && rs2 == dest));
      if (!rn || m_err) begin
         {dv, pc, ie, xe, me, we} = '0;
         {ifl, xfl, wb}           = 3'b111;
      end else begin
         dv = req;
         {pc, ie, xe, me, we} = 5'b11111;
         {ifl, xfl, wb}       = 3'b000;
         if (req && !rdy) begin
            {pc, ie, xe, me} = 4'b0000;
            wb = 1'b1;
         end else if (m_unserved == 0) begin
            if (br) begin
               ifl = 1'b1;
               xfl = 1'b1;
            end else if (haz) begin
               pc  = 1'b0;
               ie  = 1'b0;
               xfl = 1'b1;
            end
         end
      end
      exp_q.push_back({dv, pc, ie, ifl, xe, xfl, me, we, wb, m_err, SCW'(m_stall)});
      phase_q.push_back(ph);

      if (!rn) begin
         m_err      = 1'b0;
         m_unserved = 0;
         m_stall    = 0;
      end else begin
         if (!pc && m_stall < SMAX) m_stall++;
         if (!m_err) begin
            if (req && !rdy) begin
               m_unserved++;
               if (TOUT != 0 && m_unserved >= TOUT) m_err = 1'b1;
            end else begin
               m_unserved = 0;
            end
         end
      end
   endtask

   task automatic idle(input string ph, input bit rn);
      step(ph, rn, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mem(input string ph, input bit rdy);
      step(ph, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, rdy);
   endtask

   initial begin
      rstn = 1'b0;
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
      bus.ex_mem_r_en = 1'b0; bus.ex_dest = '0; bus.ex_br_taken = 1'b0;
      bus.mem_access = 1'b0; bus.dmem_ready = 1'b0;
      repeat (2) @(posedge clk);

      idle("reset", 1'b0);
      idle("reset", 1'b0);
      idle("post_reset", 1'b1);

      step("load_use", 1'b1, 1, 5, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);
      idle("after_load_use", 1'b1);
      step("load_use_x0", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      step("branch_over_lu", 1'b1, 1, 5, 1'b0, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);

      idle("reset2", 1'b0);
      repeat (3) mem("mem_wait", 1'b0);
      mem("mem_done", 1'b1);
      idle("after_mem", 1'b1);

      repeat (6) mem("timeout", 1'b0);
      step("err_hold", 1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1);
      idle("err_reset", 1'b0);
      idle("err_cleared", 1'b1);

      repeat (2) mem("wait_then_reset", 1'b0);
      step("mid_wait_reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      idle("after_mid_reset", 1'b1);
      mem("after_mid_reset_ready", 1'b1);

      for (int i = 0; i < 3000; i++) begin
         step("random",
              ($urandom_range(0, 99) >= 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 40), $urandom_range(0, 3),
              ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 99) < 25),
              ($urandom_range(0, 99) < 55));
      end

      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
